// File: rtl/ct_ifu_predecd_pkg.sv
// Shared definitions for the I-cache predecode write path: predecode field
// layout, RISC-V opcodes of interest and the refill-writer state encoding.
package ct_ifu_predecd_pkg;

   localparam int PD_IS32 = 0;
   localparam int PD_BR   = 1;
   localparam int PD_JAL  = 2;
   localparam int PD_JALR = 3;
   localparam int PD_COF  = 4;
   localparam int PD_CALL = 5;
   localparam int PD_RET  = 6;
   localparam int PD_RSVD = 7;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // x1/x5 are the link registers used by the return-address-stack hints
   function automatic logic is_link_reg(input logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

endpackage

// File: rtl/ct_ifu_predecd_hw_dec.sv
// Combinational predecoder: classifies one halfword, assumed to be an
// instruction start, into the 8-bit predecode field.
module ct_ifu_predecd_hw_dec
   import ct_ifu_predecd_pkg::*;
(
   input  logic [15:0] hw,
   output logic [7:0]  pd
);

   logic       is32;
   logic       rvc_q1;
   logic       rvc_q2;
   logic [6:0] opc;
   logic [2:0] f3;
   logic [4:0] rd_rs1;
   logic [4:0] rs2;
   logic       br32, jal32, jalr32;
   logic       cbr, cj, cjal, cjr_form, cjr, cjalr;
   logic       br, jal, jalr, call, ret;

   assign is32   = (hw[1:0] == 2'b11);
   assign rvc_q1 = (hw[1:0] == 2'b01);
   assign rvc_q2 = (hw[1:0] == 2'b10);
   assign opc    = hw[6:0];
   assign f3     = hw[15:13];
   assign rd_rs1 = hw[11:7];
   assign rs2    = hw[6:2];

   assign br32   = is32 & (opc == OPC_BRANCH);
   assign jal32  = is32 & (opc == OPC_JAL);
   assign jalr32 = is32 & (opc == OPC_JALR);

   // Quadrant 1: c.jal=001, c.j=101, c.beqz=110, c.bnez=111
   assign cbr  = rvc_q1 & (f3[2:1] == 2'b11);
   assign cj   = rvc_q1 & (f3 == 3'b101);
   assign cjal = rvc_q1 & (f3 == 3'b001);

   // Quadrant 2, funct3=100, rs2=0, rs1!=0: bit 12 separates c.jr / c.jalr
   assign cjr_form = rvc_q2 & (f3 == 3'b100) & (rs2 == 5'd0) & (rd_rs1 != 5'd0);
   assign cjr      = cjr_form & ~hw[12];
   assign cjalr    = cjr_form &  hw[12];

   assign br   = br32 | cbr;
   assign jal  = jal32 | cj | cjal;
   assign jalr = jalr32 | cjr | cjalr;
   assign call = ((jal32 | jalr32) & is_link_reg(rd_rs1)) | cjal | cjalr;
   assign ret  = (jalr32 & (rd_rs1 == 5'd0)) | (cjr & is_link_reg(rd_rs1));

   always_comb begin
      pd          = '0;
      pd[PD_IS32] = is32;
      pd[PD_BR]   = br;
      pd[PD_JAL]  = jal;
      pd[PD_JALR] = jalr;
      pd[PD_COF]  = br | jal | jalr;
      pd[PD_CALL] = call;
      pd[PD_RET]  = ret;
      pd[PD_RSVD] = 1'b0;
   end

endmodule

// File: rtl/ct_ifu_icache_predecd_refill_wr.sv
// Predecode array write controller: buffers one refill beat, predecodes it and
// writes it as two 8-byte entries, yielding to fetch reads every cycle.
module ct_ifu_icache_predecd_refill_wr
   import ct_ifu_predecd_pkg::*;
#(
   parameter int LINE_BEATS = 4,
   parameter int BEAT_W     = 128,
   parameter int IDX_W      = 16
)(
   input  logic              forever_cpuclk,
   input  logic              cpurst,
   input  logic              refill_start,
   input  logic [IDX_W-1:0]  refill_line_idx,
   input  logic              refill_beat_vld,
   input  logic [BEAT_W-1:0] refill_beat_data,
   output logic              refill_beat_rdy,
   input  logic              refill_cancel,
   input  logic              fetch_rd_req,
   output logic [IDX_W-1:0]  predecd_wr_index,
   output logic              predecd_cen_b,
   output logic              predecd_wen_b,
   output logic [31:0]       predecd_din,
   output logic              predecd_clk_en,
   output logic              predecd_wr_busy,
   output logic              predecd_wr_done
);

   localparam int CNT_W       = $clog2(LINE_BEATS);
   localparam int LINE_W      = IDX_W - CNT_W - 4;
   localparam int HW_PER_BEAT = BEAT_W / 16;

   logic [1:0]              state;
   logic                    full;
   logic                    sub;
   logic [CNT_W-1:0]        beat_cnt;
   logic [BEAT_W-1:0]       beat_buf;
   logic [LINE_W-1:0]       line_idx;
   logic [HW_PER_BEAT*8-1:0] pd_all;
   logic                    in_fill;
   logic                    wr_slot;
   logic                    last_entry;
   logic                    beat_acc;
   logic                    idx_lo_unused;

   assign idx_lo_unused = ^refill_line_idx[CNT_W+3:0];

   for (genvar g = 0; g < HW_PER_BEAT; g++) begin : g_dec
      ct_ifu_predecd_hw_dec u_dec (
         .hw (beat_buf[g*16 +: 16]),
         .pd (pd_all[g*8 +: 8])
      );
   end

   assign in_fill    = (state == ST_FILL);
   assign wr_slot    = in_fill & full & ~fetch_rd_req & ~refill_cancel;
   assign last_entry = sub & (beat_cnt == CNT_W'(LINE_BEATS - 1));

   // The freeing write of the final beat must not pull in a beat for a line
   // that is about to close.
   assign refill_beat_rdy = in_fill & ~refill_cancel
                          & (~full | (wr_slot & sub & ~last_entry));
   assign beat_acc        = refill_beat_vld & refill_beat_rdy;

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         state    <= ST_IDLE;
         full     <= 1'b0;
         sub      <= 1'b0;
         beat_cnt <= '0;
      end else if (refill_cancel) begin
         state    <= ST_IDLE;
         full     <= 1'b0;
         sub      <= 1'b0;
         beat_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (refill_start) begin
                  state    <= ST_FILL;
                  full     <= 1'b0;
                  sub      <= 1'b0;
                  beat_cnt <= '0;
               end
            end
            ST_FILL: begin
               if (beat_acc) begin
                  full <= 1'b1;
               end else if (wr_slot & sub) begin
                  full <= 1'b0;
               end
               if (wr_slot) begin
                  sub <= ~sub;
                  if (sub) begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
                  if (last_entry) begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Datapath holding registers: only ever observed behind the write slot.
   always_ff @(posedge forever_cpuclk) begin
      if ((state == ST_IDLE) && refill_start) begin
         line_idx <= refill_line_idx[IDX_W-1 -: LINE_W];
      end
      if (beat_acc) begin
         beat_buf <= refill_beat_data;
      end
   end

   assign predecd_cen_b    = ~wr_slot;
   assign predecd_wen_b    = ~wr_slot;
   assign predecd_clk_en   = wr_slot;
   assign predecd_wr_index = wr_slot ? {line_idx, beat_cnt, sub, 3'b000} : '0;
   assign predecd_din      = wr_slot ? (sub ? pd_all[63:32] : pd_all[31:0]) : '0;
   assign predecd_wr_busy  = (state != ST_IDLE);
   assign predecd_wr_done  = (state == ST_DONE);

endmodule

// File: tb/tb_ct_ifu_icache_predecd_refill_wr.sv
// Randomised bench for the predecode refill writer: a behavioural decoder and
// line model predict every array write, the rdy pattern and the done timing.
module tb_ct_ifu_icache_predecd_refill_wr;

   localparam int LINE_BEATS = 4;

   logic         forever_cpuclk = 1'b0;
   logic         cpurst = 1'b1;
   logic         refill_start = 1'b0;
   logic [15:0]  refill_line_idx = '0;
   logic         refill_beat_vld = 1'b0;
   logic [127:0] refill_beat_data = '0;
   logic         refill_beat_rdy;
   logic         refill_cancel = 1'b0;
   logic         fetch_rd_req = 1'b0;
   logic [15:0]  predecd_wr_index;
   logic         predecd_cen_b;
   logic         predecd_wen_b;
   logic [31:0]  predecd_din;
   logic         predecd_clk_en;
   logic         predecd_wr_busy;
   logic         predecd_wr_done;

   ct_ifu_icache_predecd_refill_wr #(.LINE_BEATS(4), .BEAT_W(128), .IDX_W(16)) dut (
      .forever_cpuclk   (forever_cpuclk),
      .cpurst           (cpurst),
      .refill_start     (refill_start),
      .refill_line_idx  (refill_line_idx),
      .refill_beat_vld  (refill_beat_vld),
      .refill_beat_data (refill_beat_data),
      .refill_beat_rdy  (refill_beat_rdy),
      .refill_cancel    (refill_cancel),
      .fetch_rd_req     (fetch_rd_req),
      .predecd_wr_index (predecd_wr_index),
      .predecd_cen_b    (predecd_cen_b),
      .predecd_wen_b    (predecd_wen_b),
      .predecd_din      (predecd_din),
      .predecd_clk_en   (predecd_clk_en),
      .predecd_wr_busy  (predecd_wr_busy),
      .predecd_wr_done  (predecd_wr_done)
   );

   initial forever #5 forever_cpuclk = ~forever_cpuclk;

   typedef struct {
      logic [15:0] idx;
      logic [31:0] din;
      logic        wen_b;
      logic        clk_en;
      int          cyc;
   } wr_t;

   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   wr_t          wr_q[$];
   int           done_q[$];
   wr_t          mon_w;
   logic [127:0] line_data [LINE_BEATS];
   logic         rdy_q[$];
   int           fetch_q[$];
   bit           timed_out;

   always @(posedge forever_cpuclk) cyc <= cyc + 1;

   // Observe every array write and done pulse mid-cycle
   always @(negedge forever_cpuclk) begin
      if (!cpurst) begin
         if (predecd_cen_b == 1'b0) begin
            mon_w.idx    = predecd_wr_index;
            mon_w.din    = predecd_din;
            mon_w.wen_b  = predecd_wen_b;
            mon_w.clk_en = predecd_clk_en;
            mon_w.cyc    = cyc;
            wr_q.push_back(mon_w);
         end
         if (predecd_wr_done) done_q.push_back(cyc);
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] tb_pd(input logic [15:0] h);
      logic br, jal, jalr, call, ret;
      int rd, rs2, f3;
      br = 0; jal = 0; jalr = 0; call = 0; ret = 0;
      rd = int'(h[11:7]); rs2 = int'(h[6:2]); f3 = int'(h[15:13]);
      if (h[1:0] == 2'b11) begin
         if (h[6:0] == 7'h63) br = 1;
         else if (h[6:0] == 7'h6F) begin jal = 1; call = (rd == 1 || rd == 5); end
         else if (h[6:0] == 7'h67) begin jalr = 1; call = (rd == 1 || rd == 5); ret = (rd == 0); end
      end else if (h[1:0] == 2'b01) begin
         if (f3 == 1) begin jal = 1; call = 1; end
         else if (f3 == 5) jal = 1;
         else if (f3 >= 6) br = 1;
      end else if (h[1:0] == 2'b10 && f3 == 4 && rs2 == 0 && rd != 0) begin
         jalr = 1;
         if (h[12]) call = 1;
         else ret = (rd == 1 || rd == 5);
      end
      return {1'b0, ret, call, br | jal | jalr, jalr, jal, br, h[1:0] == 2'b11};
   endfunction

   function automatic logic [15:0] exp_idx(input logic [15:0] base, input int k);
      return {base[15:6], 6'b0} + 16'(k * 8);
   endfunction

   function automatic logic [31:0] exp_din(input int k);
      logic [31:0] d;
      logic [127:0] beat;
      beat = line_data[k / 2];
      for (int j = 0; j < 4; j++) d[j*8 +: 8] = tb_pd(beat[((k % 2) * 4 + j) * 16 +: 16]);
      return d;
   endfunction

   function automatic logic [15:0] rand_hw();
      logic [15:0] h;
      logic [4:0]  regs [4];
      regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd5; regs[3] = 5'($urandom);
      h = 16'($urandom);
      case ($urandom_range(0, 5))
         0: h[6:0] = 7'h63;
         1: h[6:0] = 7'h6F;
         2: h[6:0] = 7'h67;
         3: h[1:0] = 2'b01;
         4: begin h[1:0] = 2'b10; h[15:13] = 3'b100; h[6:2] = 5'd0; end
         default: ;
      endcase
      if ($urandom_range(0, 1) == 1) h[11:7] = regs[$urandom_range(0, 3)];
      return h;
   endfunction

   task automatic fill_line();
      for (int b = 0; b < LINE_BEATS; b++)
         for (int k = 0; k < 8; k++) line_data[b][k*16 +: 16] = rand_hw();
   endtask

   // Runs one line: start pulse, beats with optional gaps, fetch window,
   // optional cancel after N writes and optional start pulse mid-line.
   task automatic drive_line(input logic [15:0] idx, input int gap, input int f_lo,
                             input int f_hi, input int cancel_at, input int restart_at);
      int  sent, gwait, w0;
      bit  acc, finished, cancelled;
      sent = 0; gwait = 0; finished = 0; cancelled = 0; timed_out = 0;
      rdy_q.delete(); fetch_q.delete();
      w0 = wr_q.size();
      @(posedge forever_cpuclk); #1;
      refill_start = 1'b1; refill_line_idx = idx;
      @(posedge forever_cpuclk); #1;
      refill_start = 1'b0; refill_line_idx = 16'($urandom);
      for (int c = 0; c < 300 && !finished; c++) begin
         refill_cancel   = (cancel_at > 0) && !cancelled && (wr_q.size() - w0 >= cancel_at);
         if (refill_cancel) cancelled = 1;
         refill_beat_vld  = !cancelled && sent < LINE_BEATS && gwait == 0;
         refill_beat_data = refill_beat_vld ? line_data[sent]
                                            : {$urandom, $urandom, $urandom, $urandom};
         fetch_rd_req     = (c >= f_lo && c <= f_hi);
         refill_start     = (c == restart_at);
         if (c == restart_at) refill_line_idx = idx ^ 16'hFFC0;
         @(negedge forever_cpuclk);
         if (fetch_rd_req) fetch_q.push_back(cyc);
         rdy_q.push_back(refill_beat_rdy);
         acc = refill_beat_vld && refill_beat_rdy;
         if (predecd_wr_done || refill_cancel) finished = 1;
         @(posedge forever_cpuclk); #1;
         if (acc) begin sent++; gwait = gap; end
         else if (gwait > 0) gwait--;
         refill_cancel = 0; refill_beat_vld = 0; fetch_rd_req = 0; refill_start = 0;
      end
      if (!finished) timed_out = 1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      refill_beat_vld = 1'b1;
      repeat (2) @(posedge forever_cpuclk);
      @(negedge forever_cpuclk);
      checks++;
      if ({predecd_cen_b, predecd_wen_b, predecd_clk_en, predecd_wr_busy, predecd_wr_done,
           refill_beat_rdy} !== 6'b110000) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 110000", {predecd_cen_b, predecd_wen_b,
                  predecd_clk_en, predecd_wr_busy, predecd_wr_done, refill_beat_rdy});
      end
      checks++;
      if ({predecd_wr_index, predecd_din} !== 48'h0) begin
         errors++;
         $display("FAIL reset_bus got %h_%h want 0", predecd_wr_index, predecd_din);
      end
      @(posedge forever_cpuclk); #1;
      cpurst = 1'b0; refill_beat_vld = 1'b0;
   endtask

   task automatic test_vld_outside_fill();
      refill_beat_vld = 1'b1;
      refill_beat_data = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 3; i++) begin
         @(negedge forever_cpuclk);
         checks++;
         if (refill_beat_rdy !== 1'b0 || predecd_cen_b !== 1'b1) begin
            errors++;
            $display("FAIL idle_vld rdy=%b cen_b=%b want rdy=0 cen_b=1", refill_beat_rdy, predecd_cen_b);
         end
      end
      @(posedge forever_cpuclk); #1;
      refill_beat_vld = 1'b0;
   endtask

   task automatic test_clean_line();
      int w0, d0, n;
      fill_line();
      line_data[0][63:0] = 64'h8082_A001_0000_00EF;
      w0 = wr_q.size(); d0 = done_q.size();
      drive_line(16'h1240, 0, -1, -1, 0, -1);
      n = wr_q.size() - w0;
      checks++;
      if (timed_out || n != 8) begin
         errors++; $display("FAIL clean_count got %0d timeout=%0d want 8", n, timed_out);
      end
      for (int k = 0; k < n && k < 8; k++) begin
         checks++;
         if (wr_q[w0+k].idx !== exp_idx(16'h1240, k) || wr_q[w0+k].din !== exp_din(k)
             || wr_q[w0+k].cyc != wr_q[w0].cyc + k || wr_q[w0+k].wen_b !== 1'b0
             || wr_q[w0+k].clk_en !== 1'b1) begin
            errors++;
            $display("FAIL clean_wr%0d got idx=%h din=%h cyc=%0d want idx=%h din=%h cyc=%0d", k,
                     wr_q[w0+k].idx, wr_q[w0+k].din, wr_q[w0+k].cyc, exp_idx(16'h1240, k),
                     exp_din(k), wr_q[w0].cyc + k);
         end
      end
      if (n >= 1) begin
         checks++;
         if (wr_q[w0].din !== {8'h58, 8'h14, 8'h00, 8'h35}) begin
            errors++; $display("FAIL decode_entry0 got %h want 58140035", wr_q[w0].din);
         end
      end
      for (int c = 0; c < 8 && c < rdy_q.size(); c++) begin
         checks++;
         if (rdy_q[c] !== ((c % 2) == 0)) begin
            errors++; $display("FAIL clean_rdy%0d got %b want %b", c, rdy_q[c], (c % 2) == 0);
         end
      end
      checks++;
      if (done_q.size() - d0 != 1 || n == 0 || done_q[done_q.size()-1] != wr_q[wr_q.size()-1].cyc + 1) begin
         errors++; $display("FAIL clean_done got %0d pulses want 1 right after last write", done_q.size() - d0);
      end
      @(negedge forever_cpuclk);
      checks++;
      if (predecd_wr_busy !== 1'b0 || predecd_wr_done !== 1'b0) begin
         errors++; $display("FAIL clean_idle got busy=%b done=%b want 0 0", predecd_wr_busy, predecd_wr_done);
      end
   endtask

   task automatic test_random_lines();
      int w0, d0, n, gap;
      logic [15:0] idx;
      for (int l = 0; l < 3; l++) begin
         fill_line();
         idx = 16'($urandom); gap = $urandom_range(0, 2);
         w0 = wr_q.size(); d0 = done_q.size();
         drive_line(idx, gap, -1, -1, 0, 3);
         n = wr_q.size() - w0;
         checks++;
         if (timed_out || n != 8 || done_q.size() - d0 != 1) begin
            errors++; $display("FAIL rand%0d_count got %0d writes %0d dones want 8 1", l, n, done_q.size() - d0);
         end
         for (int k = 0; k < n && k < 8; k++) begin
            checks++;
            if (wr_q[w0+k].idx !== exp_idx(idx, k) || wr_q[w0+k].din !== exp_din(k)) begin
               errors++;
               $display("FAIL rand%0d_wr%0d got %h/%h want %h/%h", l, k, wr_q[w0+k].idx,
                        wr_q[w0+k].din, exp_idx(idx, k), exp_din(k));
            end
         end
      end
   endtask

   task automatic test_fetch_priority();
      int w0, d0, n, overlap;
      logic [15:0] idx;
      fill_line();
      idx = 16'h8A40;
      w0 = wr_q.size(); d0 = done_q.size();
      drive_line(idx, 0, 3, 5, 0, -1);
      n = wr_q.size() - w0; overlap = 0;
      for (int k = 0; k < n; k++)
         foreach (fetch_q[f]) if (fetch_q[f] == wr_q[w0+k].cyc) overlap++;
      checks++;
      if (timed_out || n != 8 || overlap != 0 || fetch_q.size() != 3) begin
         errors++;
         $display("FAIL fetch_prio got writes=%0d overlap=%0d fetch_cycles=%0d want 8 0 3", n, overlap, fetch_q.size());
      end
      for (int k = 0; k < n && k < 8; k++) begin
         checks++;
         if (wr_q[w0+k].idx !== exp_idx(idx, k) || wr_q[w0+k].din !== exp_din(k)) begin
            errors++;
            $display("FAIL fetch_wr%0d got %h/%h want %h/%h", k, wr_q[w0+k].idx, wr_q[w0+k].din,
                     exp_idx(idx, k), exp_din(k));
         end
      end
      checks++;
      if (done_q.size() - d0 != 1 || n == 0 || done_q[done_q.size()-1] != wr_q[wr_q.size()-1].cyc + 1) begin
         errors++; $display("FAIL fetch_done got %0d pulses want 1 after last write", done_q.size() - d0);
      end
   endtask

   task automatic test_stall_gaps();
      int w0, d0, n, span;
      logic [15:0] idx;
      fill_line();
      idx = 16'h03C0;
      w0 = wr_q.size(); d0 = done_q.size();
      drive_line(idx, 3, -1, -1, 0, -1);
      n = wr_q.size() - w0;
      span = (n > 0) ? wr_q[wr_q.size()-1].cyc - wr_q[w0].cyc : 0;
      // beats arrive every 4 cycles, each written in the two cycles after arrival
      checks++;
      if (timed_out || n != 8 || span != 13) begin
         errors++; $display("FAIL gap_timing got writes=%0d span=%0d want 8 13", n, span);
      end
      for (int k = 0; k < n && k < 8; k++) begin
         checks++;
         if (wr_q[w0+k].idx !== exp_idx(idx, k) || wr_q[w0+k].din !== exp_din(k)) begin
            errors++;
            $display("FAIL gap_wr%0d got %h/%h want %h/%h", k, wr_q[w0+k].idx, wr_q[w0+k].din,
                     exp_idx(idx, k), exp_din(k));
         end
      end
      checks++;
      if (done_q.size() - d0 != 1 || n == 0 || done_q[done_q.size()-1] != wr_q[wr_q.size()-1].cyc + 1) begin
         errors++; $display("FAIL gap_done got %0d pulses want 1 after last write", done_q.size() - d0);
      end
   endtask

   task automatic test_cancel();
      int w0, d0, n;
      logic [15:0] idx;
      fill_line();
      idx = 16'h5F80;
      w0 = wr_q.size(); d0 = done_q.size();
      drive_line(idx, 0, -1, -1, 5, -1);
      @(negedge forever_cpuclk);
      checks++;
      if (predecd_wr_busy !== 1'b0 || predecd_cen_b !== 1'b1) begin
         errors++; $display("FAIL cancel_idle got busy=%b cen_b=%b want 0 1", predecd_wr_busy, predecd_cen_b);
      end
      repeat (5) @(posedge forever_cpuclk);
      n = wr_q.size() - w0;
      checks++;
      if (timed_out || n != 5 || done_q.size() != d0) begin
         errors++; $display("FAIL cancel_count got writes=%0d dones=%0d want 5 0", n, done_q.size() - d0);
      end
      fill_line();
      idx = 16'h2200;
      w0 = wr_q.size(); d0 = done_q.size();
      drive_line(idx, 0, -1, -1, 0, -1);
      n = wr_q.size() - w0;
      checks++;
      if (timed_out || n != 8 || done_q.size() - d0 != 1) begin
         errors++; $display("FAIL cancel_restart got writes=%0d dones=%0d want 8 1", n, done_q.size() - d0);
      end
      for (int k = 0; k < n && k < 8; k++) begin
         checks++;
         if (wr_q[w0+k].idx !== exp_idx(idx, k) || wr_q[w0+k].din !== exp_din(k)) begin
            errors++;
            $display("FAIL restart_wr%0d got %h/%h want %h/%h", k, wr_q[w0+k].idx, wr_q[w0+k].din,
                     exp_idx(idx, k), exp_din(k));
         end
      end
   endtask

   task automatic test_async_reset();
      int w0, d0, n;
      bit got3;
      logic [15:0] idx;
      fill_line();
      w0 = wr_q.size(); got3 = 0;
      @(posedge forever_cpuclk); #1;
      refill_start = 1'b1; refill_line_idx = 16'hC0C0;
      @(posedge forever_cpuclk); #1;
      refill_start = 1'b0;
      refill_beat_vld = 1'b1; refill_beat_data = line_data[0];
      for (int c = 0; c < 40 && !got3; c++) begin
         @(negedge forever_cpuclk);
         if (wr_q.size() - w0 >= 3 && predecd_cen_b == 1'b0) got3 = 1;
         else begin @(posedge forever_cpuclk); #1; end
      end
      checks++;
      if (!got3) begin
         errors++; $display("FAIL arst_setup got no write in flight want one");
      end
      #1 cpurst = 1'b1;
      #1;
      checks++;
      if ({predecd_cen_b, predecd_wen_b, predecd_clk_en, predecd_wr_busy, predecd_wr_done,
           refill_beat_rdy, predecd_wr_index, predecd_din} !== {6'b110000, 48'h0}) begin
         errors++;
         $display("FAIL arst_outputs got cen_b=%b wen_b=%b clk_en=%b busy=%b done=%b rdy=%b idx=%h din=%h want reset values",
                  predecd_cen_b, predecd_wen_b, predecd_clk_en, predecd_wr_busy, predecd_wr_done,
                  refill_beat_rdy, predecd_wr_index, predecd_din);
      end
      @(posedge forever_cpuclk); #1;
      refill_beat_vld = 1'b0;
      @(posedge forever_cpuclk); #1;
      cpurst = 1'b0;
      fill_line();
      idx = 16'h7E40;
      w0 = wr_q.size(); d0 = done_q.size();
      drive_line(idx, 1, -1, -1, 0, -1);
      n = wr_q.size() - w0;
      checks++;
      if (timed_out || n != 8 || done_q.size() - d0 != 1) begin
         errors++; $display("FAIL arst_line got writes=%0d dones=%0d want 8 1", n, done_q.size() - d0);
      end
      for (int k = 0; k < n && k < 8; k++) begin
         checks++;
         if (wr_q[w0+k].idx !== exp_idx(idx, k) || wr_q[w0+k].din !== exp_din(k)) begin
            errors++;
            $display("FAIL arst_wr%0d got %h/%h want %h/%h", k, wr_q[w0+k].idx, wr_q[w0+k].din,
                     exp_idx(idx, k), exp_din(k));
         end
      end
   endtask

   initial begin
      test_reset();
      test_vld_outside_fill();
      test_clean_line();
      test_random_lines();
      test_fetch_priority();
      test_stall_gaps();
      test_cancel();
      test_async_reset();
      repeat (2) @(posedge forever_cpuclk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
